uart_rx_fifo: RTL and testbench

- Buffers bytes produced by the Uart8 receiver and presents them on a first-word-fall-through valid/ready read port.
- Each stored byte carries its framing-error flag.
- Tracks overflow (sticky flag plus saturating drop counter) and standalone receive errors (saturating error counter).
- Sits directly downstream of Uart8's rx interface, in the same clk domain.

---
 rtl/uart_rx_fifo_if.sv | 28 ++
 rtl/uart_rx_fifo.sv | 129 ++++++++++++
 tb/tb_uart_rx_fifo.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_fifo_if.sv
// Read-side handshake bundle for uart_rx_fifo.
//
// The FIFO is the master: it presents the head entry (outData/outErr)
// together with outValid, and the consumer answers with outReady.
//   outValid  master -> slave  head entry is present
//   outReady  slave  -> master consumer accepts the head entry this cycle
//   outData   master -> slave  head byte
//   outErr    master -> slave  framing-error flag stored with the head byte
interface uart_rx_fifo_if;
    logic       outValid;
    logic       outReady;
    logic [7:0] outData;
    logic       outErr;

    modport master (
        output outValid,
        output outData,
        output outErr,
        input  outReady
    );

    modport slave (
        input  outValid,
        input  outData,
        input  outErr,
        output outReady
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// Receive FIFO placed directly behind the Uart8 receiver (same clk domain).
//
// Each byte completed by the receiver (rising edge of rxDone) is stored with
// its framing-error flag and offered on a first-word-fall-through
// valid/ready port. A byte arriving while the FIFO is full and not being
// drained in the same cycle is dropped; this sets a sticky overflow flag and
// bumps a saturating drop counter. Receive errors that arrive without a
// completed byte are counted in a separate saturating counter.
//
// Ports:
//   clk            system clock, rising edge
//   reset          asynchronous, active-low reset
//   rxDone         Uart8 byte-complete strobe (level or pulse)
//   rxErr          Uart8 framing-error flag
//   rxOut[7:0]     Uart8 received byte, valid while rxDone is high
//   rd             read port (master modport): outValid/outReady/outData/outErr
//   count          occupancy, 0..2**ADDR_W
//   full           count == 2**ADDR_W
//   overflow       sticky, set when a byte is dropped
//   clearOverflow  synchronous clear of overflow (a same-cycle drop wins)
//   dropCount      dropped bytes, saturating
//   errCount       standalone rxErr rising edges, saturating
module uart_rx_fifo #(
    parameter int ADDR_W = 4,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rxDone,
    input  logic              rxErr,
    input  logic [7:0]        rxOut,
    uart_rx_fifo_if.master    rd,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              overflow,
    input  logic              clearOverflow,
    output logic [CNT_W-1:0]  dropCount,
    output logic [CNT_W-1:0]  errCount
);
    localparam int              DEPTH      = 1 << ADDR_W;
    localparam logic [ADDR_W:0] FULL_COUNT = {1'b1, {ADDR_W{1'b0}}};

    // Entry layout: {framing error, data byte}.
    logic [8:0]        mem [DEPTH];
    logic [ADDR_W-1:0] wrPtr;
    logic [ADDR_W-1:0] rdPtr;
    logic              rxDoneQ;
    logic              rxErrQ;

    logic push;
    logic pop;
    logic accept;
    logic drop;
    logic errEdge;

    // Status comes straight from the count register, so outReady has no
    // combinational path to outValid.
    assign full        = (count == FULL_COUNT);
    assign rd.outValid = (count != '0);

    // Head is addressed by a registered pointer: no read latency, and a write
    // to the tail never disturbs what is currently presented.
    assign rd.outData = mem[rdPtr][7:0];
    assign rd.outErr  = mem[rdPtr][8];

    // A level-held rxDone still produces exactly one write.
    assign push = rxDone & ~rxDoneQ;
    assign pop  = rd.outValid & rd.outReady;

    // When full, a same-cycle pop frees the slot the push needs.
    assign accept = push & (~full | pop);
    assign drop   = push & full & ~pop;

    // Errors that come with a completed byte live only in the stored flag.
    assign errEdge = rxErr & ~rxErrQ & ~rxDone;

    // NOTE: the storage array has no reset; entries are only observable after
    // a write, and leaving it out keeps the array a plain register file.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wrPtr] <= {rxErr, rxOut};
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rxDoneQ   <= 1'b0;
            rxErrQ    <= 1'b0;
            wrPtr     <= '0;
            rdPtr     <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            dropCount <= '0;
            errCount  <= '0;
        end else begin
            rxDoneQ <= rxDone;
            rxErrQ  <= rxErr;

            if (accept) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (pop) begin
                rdPtr <= rdPtr + 1'b1;
            end

            if (accept && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !accept) begin
                count <= count - 1'b1;
            end

            // Set has priority over clear so a drop is never lost.
            if (drop) begin
                overflow <= 1'b1;
            end else if (clearOverflow) begin
                overflow <= 1'b0;
            end

            if (drop && (dropCount != '1)) begin
                dropCount <= dropCount + 1'b1;
            end
            if (errEdge && (errCount != '1)) begin
                errCount <= errCount + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo. A queue holds the entries the FIFO
// should contain; stimulus pushes into it, reads pop from it and compare.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_uart_rx_fifo;
    localparam int ADDR_W = 4;
    localparam int CNT_W  = 8;
    localparam int DEPTH  = 16;
    localparam int SAT    = 255;

    logic              clk           = 1'b0;
    logic              reset         = 1'b0;
    logic              rxDone        = 1'b0;
    logic              rxErr         = 1'b0;
    logic [7:0]        rxOut         = 8'h00;
    logic              clearOverflow = 1'b0;
    logic [ADDR_W:0]   count;
    logic              full;
    logic              overflow;
    logic [CNT_W-1:0]  dropCount;
    logic [CNT_W-1:0]  errCount;

    uart_rx_fifo_if rdIf ();

    uart_rx_fifo #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .reset         (reset),
        .rxDone        (rxDone),
        .rxErr         (rxErr),
        .rxOut         (rxOut),
        .rd            (rdIf),
        .count         (count),
        .full          (full),
        .overflow      (overflow),
        .clearOverflow (clearOverflow),
        .dropCount     (dropCount),
        .errCount      (errCount)
    );

    always #5 clk = ~clk;

    // Reference model state.
    logic [8:0] expQ[$];
    int         expDrop     = 0;
    int         expErr      = 0;
    logic       expOverflow = 1'b0;

    int passCnt  = 0;
    int totalCnt = 0;

    task automatic tick();
        @(negedge clk);
    endtask

    // Model of one byte arriving; popping says a read happens in the same cycle.
    task automatic modelPush(input logic [7:0] d, input logic e, input bit popping);
        if (expQ.size() < DEPTH || popping) begin
            expQ.push_back({e, d});
        end else begin
            expOverflow = 1'b1;
            if (expDrop < SAT) expDrop++;
        end
    endtask

    // One-cycle rxDone pulse followed by one idle cycle.
    task automatic pushByte(input logic [7:0] d, input logic e);
        rxOut  = d;
        rxErr  = e;
        rxDone = 1'b1;
        modelPush(d, e, 1'b0);
        tick();
        rxDone = 1'b0;
        rxErr  = 1'b0;
        tick();
    endtask

    // Read everything the model expects, comparing each head, then confirm empty.
    task automatic drain(input string tag);
        logic [8:0] exp;
        rdIf.outReady = 1'b1;
        while (expQ.size() > 0) begin
            exp = expQ.pop_front();
            totalCnt++;
            if (rdIf.outValid !== 1'b1 || rdIf.outData !== exp[7:0] || rdIf.outErr !== exp[8])
                $display("FAIL %s_read: got valid=%b data=%h err=%b, expected valid=1 data=%h err=%b",
                         tag, rdIf.outValid, rdIf.outData, rdIf.outErr, exp[7:0], exp[8]);
            else passCnt++;
            tick();
        end
        rdIf.outReady = 1'b0;
        totalCnt++;
        if (rdIf.outValid !== 1'b0 || count !== '0)
            $display("FAIL %s_empty: got valid=%b count=%0d, expected valid=0 count=0",
                     tag, rdIf.outValid, count);
        else passCnt++;
    endtask

    task automatic checkStatus(input string tag, input int expCount);
        totalCnt++;
        if (count !== (ADDR_W+1)'(expCount) || full !== (expCount == DEPTH) ||
            rdIf.outValid !== (expCount != 0))
            $display("FAIL %s_occupancy: got count=%0d full=%b valid=%b, expected count=%0d full=%b valid=%b",
                     tag, count, full, rdIf.outValid, expCount, expCount == DEPTH, expCount != 0);
        else passCnt++;
        totalCnt++;
        if (overflow !== expOverflow || dropCount !== CNT_W'(expDrop) || errCount !== CNT_W'(expErr))
            $display("FAIL %s_flags: got ovf=%b drop=%0d err=%0d, expected ovf=%b drop=%0d err=%0d",
                     tag, overflow, dropCount, errCount, expOverflow, expDrop, expErr);
        else passCnt++;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (10) tick();
        reset = 1'b1;
        tick();
        checkStatus("reset", 0);
        // outReady while empty must be ignored.
        rdIf.outReady = 1'b1;
        repeat (3) tick();
        rdIf.outReady = 1'b0;
        checkStatus("empty_ready", 0);
    endtask

    task automatic test_level_hold();
        rxOut  = 8'h56;
        rxErr  = 1'b0;
        rxDone = 1'b1;
        modelPush(8'h56, 1'b0, 1'b0);
        tick();
        totalCnt++;
        if (rdIf.outValid !== 1'b1 || rdIf.outData !== 8'h56 || rdIf.outErr !== 1'b0 || count !== 5'd1)
            $display("FAIL first_push: got valid=%b data=%h err=%b count=%0d, expected valid=1 data=56 err=0 count=1",
                     rdIf.outValid, rdIf.outData, rdIf.outErr, count);
        else passCnt++;
        repeat (49) tick();
        checkStatus("level_hold", 1);
        rxDone = 1'b0;
        tick();
        drain("level_hold");
    endtask

    task automatic test_overflow();
        for (int i = 0; i < DEPTH; i++) pushByte(8'(i), 1'b0);
        checkStatus("filled", DEPTH);
        pushByte(8'hAA, 1'b0);
        checkStatus("overflow", DEPTH);
        drain("overflow");
    endtask

    task automatic test_full_push_pop();
        for (int i = 0; i < DEPTH; i++) pushByte(8'h40 + 8'(i), 1'b0);
        // Push 8'hBB in the same cycle as popping the head.
        totalCnt++;
        if (rdIf.outValid !== 1'b1 || rdIf.outData !== expQ[0][7:0])
            $display("FAIL full_head: got valid=%b data=%h, expected valid=1 data=%h",
                     rdIf.outValid, rdIf.outData, expQ[0][7:0]);
        else passCnt++;
        rdIf.outReady = 1'b1;
        rxOut  = 8'hBB;
        rxDone = 1'b1;
        void'(expQ.pop_front());
        modelPush(8'hBB, 1'b0, 1'b1);
        tick();
        rdIf.outReady = 1'b0;
        rxDone = 1'b0;
        tick();
        checkStatus("full_push_pop", DEPTH);
        // Plain clear.
        clearOverflow = 1'b1;
        expOverflow   = 1'b0;
        tick();
        clearOverflow = 1'b0;
        tick();
        checkStatus("clear_ovf", DEPTH);
        // Clear in the same cycle as a drop: set wins.
        clearOverflow = 1'b1;
        rxOut  = 8'hCC;
        rxDone = 1'b1;
        modelPush(8'hCC, 1'b0, 1'b0);
        tick();
        clearOverflow = 1'b0;
        rxDone = 1'b0;
        tick();
        checkStatus("clear_vs_drop", DEPTH);
        drain("full_push_pop");
    endtask

    task automatic test_back_to_back();
        pushByte(8'h11, 1'b0);
        rdIf.outReady = 1'b1;
        rxOut  = 8'h22;
        rxDone = 1'b1;
        totalCnt++;
        if (rdIf.outData !== 8'h11)
            $display("FAIL b2b_head: got data=%h, expected data=11", rdIf.outData);
        else passCnt++;
        void'(expQ.pop_front());
        modelPush(8'h22, 1'b0, 1'b1);
        tick();
        rdIf.outReady = 1'b0;
        rxDone = 1'b0;
        tick();
        checkStatus("back_to_back", 1);
        drain("back_to_back");
    endtask

    task automatic test_errors();
        pushByte(8'h3C, 1'b1);
        checkStatus("err_with_byte", 1);
        drain("err_with_byte");
        repeat (3) begin
            rxErr = 1'b1;
            if (expErr < SAT) expErr++;
            tick();
            rxErr = 1'b0;
            tick();
        end
        checkStatus("err_three", 0);
        repeat (300) begin
            rxErr = 1'b1;
            if (expErr < SAT) expErr++;
            tick();
            rxErr = 1'b0;
            tick();
        end
        checkStatus("err_saturate", 0);
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < 5; i++) pushByte(8'h70 + 8'(i), 1'b0);
        checkStatus("pre_reset", 5);
        #2 reset = 1'b0;
        #1;
        expQ.delete();
        expDrop     = 0;
        expErr      = 0;
        expOverflow = 1'b0;
        checkStatus("async_reset", 0);
        tick();
        reset = 1'b1;
        tick();
        pushByte(8'h81, 1'b0);
        checkStatus("post_reset", 1);
        drain("post_reset");
    endtask

    initial begin
        rdIf.outReady = 1'b0;
        test_reset();
        test_level_hold();
        test_overflow();
        test_full_push_pop();
        test_back_to_back();
        test_errors();
        test_mid_reset();
        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion earlier", $time);
        $fatal(1, "watchdog expired");
    end
endmodule
